// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port data memory between two requesters,
// serializing accesses as fixed two-cycle transactions with registered read-data return.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t                state_q;
    logic                  ptr_q, win_q, win_d;
    logic                  gnt0_q, gnt1_q, rvalid0_q, rvalid1_q, mem_we_q, mem_re_q;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q, mem_data_q;
    logic [ADDR_WIDTH-1:0] mem_address_q;
    // ptr_q holds the last granted port; on a tie the other port wins
    assign win_d = (req0 && req1) ? ~ptr_q : req1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= 1'b1;
            win_q         <= 1'b0;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            rvalid0_q     <= 1'b0;
            rvalid1_q     <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            mem_we_q      <= 1'b0;
            mem_re_q      <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
        end else begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            if (state_q == IDLE) begin
                if (req0 || req1) begin
                    state_q       <= ACCESS;
                    win_q         <= win_d;
                    gnt0_q        <= ~win_d;
                    gnt1_q        <= win_d;
                    mem_address_q <= win_d ? addr1 : addr0;
                    mem_data_q    <= win_d ? wdata1 : wdata0;
                    mem_we_q      <= win_d ? we1 : we0;
                    mem_re_q      <= win_d ? ~we1 : ~we0;
                end
            end else begin
                state_q  <= IDLE;
                ptr_q    <= win_q;
                gnt0_q   <= 1'b0;
                gnt1_q   <= 1'b0;
                mem_we_q <= 1'b0;
                mem_re_q <= 1'b0;
                // memory drove read data on the falling edge mid-ACCESS
                if (mem_re_q && !win_q) begin
                    rdata0_q  <= mem_data_out;
                    rvalid0_q <= 1'b1;
                end
                if (mem_re_q && win_q) begin
                    rdata1_q  <= mem_data_out;
                    rvalid1_q <= 1'b1;
                end
            end
        end
    end
    assign busy        = (state_q == ACCESS);
    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign rvalid0     = rvalid0_q;
    assign rvalid1     = rvalid1_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign mem_we      = mem_we_q;
    assign mem_re      = mem_re_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized scoreboard bench for mem_arbiter with a
// transaction-level reference model and a behavioural memory.
module tb_mem_arbiter;
    typedef struct packed {
        logic        p;
        logic        we;
        logic [7:0]  a;
        logic [31:0] d;
    } g_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  we = 2'b00;
    logic [1:0]  gnt, rvalid;
    logic [7:0]  addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        busy, mem_we, mem_re;
    logic [7:0]  mem_address;
    logic [31:0] mem_data, mem_data_out;
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    g_t          gq [$];
    logic [31:0] rq0 [$];
    logic [31:0] rq1 [$];
    int          total = 0;
    int          bad = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
        .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
        .gnt0(gnt[0]), .gnt1(gnt[1]), .rvalid0(rvalid[0]), .rvalid1(rvalid[1]),
        .rdata0(rdata[0]), .rdata1(rdata[1]), .busy(busy),
        .mem_address(mem_address), .mem_data(mem_data), .mem_we(mem_we), .mem_re(mem_re),
        .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        return (i == 8'h10) ? 32'hDEADBEEF : (i == 8'h20) ? 32'h0 :
               {8'(i), 8'(~i), 8'(i * 3), 8'hA5};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // memory: writes on rising edge, reads on falling edge
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (mem_we) mem[mem_address] = mem_data;
        end
    end
    initial begin
        mem_data_out = '0;
        forever begin
            @(negedge clk);
            if (mem_re) mem_data_out = mem[mem_address];
        end
    end

    // reference model: one transaction per grant, write committed when the access completes
    initial begin
        logic busy_m, ptr_m, pw, w;
        logic [7:0]  pa;
        logic [31:0] pd;
        busy_m = 1'b0; ptr_m = 1'b1; pw = 1'b0; pa = '0; pd = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                busy_m = 1'b0; ptr_m = 1'b1; pw = 1'b0;
                gq.delete(); rq0.delete(); rq1.delete();
            end else if (busy_m) begin
                busy_m = 1'b0;
                if (pw) ref_mem[pa] = pd;
                pw = 1'b0;
            end else if (req != 2'b00) begin
                w = (req == 2'b11) ? !ptr_m : req[1];
                ptr_m = w;
                busy_m = 1'b1;
                gq.push_back('{p: w, we: we[w], a: addr[w], d: wdata[w]});
                if (we[w]) begin
                    pw = 1'b1; pa = addr[w]; pd = wdata[w];
                end else if (w) rq1.push_back(ref_mem[addr[w]]);
                else rq0.push_back(ref_mem[addr[w]]);
            end
        end
    end

    initial begin
        g_t          e;
        logic [7:0]  la;
        logic [31:0] ld;
        logic [31:0] lr [2];
        la = '0; ld = '0; lr[0] = '0; lr[1] = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                la = '0; ld = '0; lr[0] = '0; lr[1] = '0;
            end else begin
                chk("we_re_excl", 32'(mem_we & mem_re), 0);
                chk("busy", 32'(busy), 32'(gnt[0] | gnt[1]));
                if (gnt != 2'b00) begin
                    if (gq.size() == 0) chk("gnt_unexp", 32'(gnt), 0);
                    else begin
                        e = gq.pop_front();
                        chk("gnt_port", 32'(gnt), e.p ? 2 : 1);
                        chk("mem_addr", 32'(mem_address), 32'(e.a));
                        chk("mem_we", 32'(mem_we), 32'(e.we));
                        chk("mem_re", 32'(mem_re), 32'(!e.we));
                        chk("mem_data", mem_data, e.d);
                        la = e.a; ld = e.d;
                    end
                end else begin
                    chk("idle_ctl", 32'({mem_we, mem_re}), 0);
                    chk("idle_addr", 32'(mem_address), 32'(la));
                    chk("idle_data", mem_data, ld);
                end
                if (rvalid[0]) begin
                    if (rq0.size() == 0) chk("rvalid0_unexp", 32'(rvalid[0]), 0);
                    else begin
                        lr[0] = rq0.pop_front();
                        chk("rdata0", rdata[0], lr[0]);
                    end
                end else chk("rdata0_hold", rdata[0], lr[0]);
                if (rvalid[1]) begin
                    if (rq1.size() == 0) chk("rvalid1_unexp", 32'(rvalid[1]), 0);
                    else begin
                        lr[1] = rq1.pop_front();
                        chk("rdata1", rdata[1], lr[1]);
                    end
                end else chk("rdata1_hold", rdata[1], lr[1]);
            end
        end
    end

    task automatic check_reset();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_rdata0", rdata[0], 0);
        chk("rst_rdata1", rdata[1], 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ctl", 32'({mem_we, mem_re}), 0);
        chk("rst_addr", 32'(mem_address), 0);
        chk("rst_data", mem_data, 0);
    endtask

    task automatic issue(input int p, input logic w, input logic [7:0] a, input logic [31:0] d);
        int k;
        req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!gnt[p] && k < 20);
        if (!gnt[p]) chk("gnt_timeout", 32'(gnt[p]), 1);
        req[p] = 1'b0;
    endtask

    initial begin
        int k;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset();
        // tie from reset: port 0 first, then alternate every two cycles
        req = 2'b11; we = 2'b00; addr[0] = 8'h01; addr[1] = 8'h02;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("tie_gnt", 32'(gnt), (i % 4 == 1) ? 1 : (i % 4 == 3) ? 2 : 0);
            chk("tie_busy", 32'(busy), 32'(i % 2));
        end
        req = 2'b00;
        @(negedge clk);
        issue(0, 1'b0, 8'h10, 32'h0);
        chk("rd_re", 32'(mem_re), 1);
        chk("rd_addr", 32'(mem_address), 32'h10);
        @(negedge clk);
        chk("rd_rvalid", 32'(rvalid), 1);
        chk("rd_data", rdata[0], 32'hDEADBEEF);
        issue(1, 1'b1, 8'h3F, 32'h12345678);
        chk("wr_we", 32'(mem_we), 1);
        issue(1, 1'b0, 8'h3F, 32'h0);
        @(negedge clk);
        chk("wr_rd_rvalid", 32'(rvalid), 2);
        chk("wr_rd_data", rdata[1], 32'h12345678);
        issue(0, 1'b0, 8'h05, 32'h0);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 8'h06;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!gnt[1] && k < 10);
        chk("access_gap", 32'(k), 2);
        req[1] = 1'b0;
        @(negedge clk);
        issue(0, 1'b0, 8'hFF, 32'h0);
        @(negedge clk);
        chk("wrap_ff", rdata[0], init_val(255));
        issue(0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        chk("wrap_00", rdata[0], init_val(0));
        issue(1, 1'b1, 8'h20, 32'hAAAA5555);
        chk("rw_we", 32'(mem_we), 1);
        #1 rst = 1'b1;
        #1;
        chk("rw_async_ctl", 32'({mem_we, mem_re}), 0);
        chk("rw_async_busy", 32'(busy), 0);
        chk("rw_async_gnt", 32'(gnt), 0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rw_mem20", mem[8'h20], 32'h0);
        check_reset();
        repeat (400) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (!req[p] || gnt[p]) begin
                    req[p] = ($urandom_range(0, 9) < 6);
                    we[p] = 1'($urandom_range(0, 1));
                    addr[p] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
                    wdata[p] = $urandom;
                end
            end
        end
        @(negedge clk);
        req = 2'b00;
        repeat (4) @(negedge clk);
        chk("gq_drained", 32'(gq.size()), 0);
        chk("rq0_drained", 32'(rq0.size()), 0);
        chk("rq1_drained", 32'(rq1.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
